// File: rtl/axilite_gpio_irq.sv
// -----------------------------------------------------------------------------
// axilite_gpio_irq
//
// AXI4-Lite GPIO slave with input synchronisation, per-pin edge detection,
// sticky maskable interrupt status and a single registered level interrupt.
//
// Register map (address bits [4:2] decoded, unused upper bits read 0):
//   0x00 DATA_IN   RO   synchronised input pins
//   0x04 DATA_OUT  RW   drives gpio_out_o
//   0x08 IRQ_EN    RW   per-pin interrupt enable
//   0x0C EDGE_SEL  RW   0 = rising edge, 1 = falling edge
//   0x10 STATUS    W1C  sticky edge-detected flags
//   other offsets: reads return 0 + SLVERR, writes ignored + SLVERR
//
// Ports:
//   clock_i, reset_i          clock, asynchronous active-high reset
//   s_axilite_aw*/w*/b*       AXI4-Lite write address / data / response
//   s_axilite_ar*/r*          AXI4-Lite read address / data
//   gpio_in_i  [NUM_IN-1:0]   asynchronous input pins
//   gpio_out_o [NUM_OUT-1:0]  registered output pins
//   irq_o                     high while any bit of (STATUS & IRQ_EN) is set
//
// Handshake semantics: a transfer on any channel occurs on a rising clock edge
// where both valid and ready are high. The slave raises awready and wready
// together for exactly one cycle, and only once both awvalid and wvalid have
// been seen; arready is likewise a one-cycle pulse. bvalid/rvalid are held,
// with their payload stable, until the matching bready/rready is seen.
// Only one write and one read may be outstanding; the two channels are
// independent.
//
// FSM state is visible as w_state_q / r_state_q.
// -----------------------------------------------------------------------------
module axilite_gpio_irq #(
    parameter int NUM_IN     = 16,
    parameter int NUM_OUT    = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [ADDR_WIDTH-1:0] s_axilite_awaddr,
    input  logic                  s_axilite_awvalid,
    output logic                  s_axilite_awready,
    input  logic [31:0]           s_axilite_wdata,
    input  logic [3:0]            s_axilite_wstrb,
    input  logic                  s_axilite_wvalid,
    output logic                  s_axilite_wready,
    output logic [1:0]            s_axilite_bresp,
    output logic                  s_axilite_bvalid,
    input  logic                  s_axilite_bready,
    input  logic [ADDR_WIDTH-1:0] s_axilite_araddr,
    input  logic                  s_axilite_arvalid,
    output logic                  s_axilite_arready,
    output logic [31:0]           s_axilite_rdata,
    output logic [1:0]            s_axilite_rresp,
    output logic                  s_axilite_rvalid,
    input  logic                  s_axilite_rready,
    input  logic [NUM_IN-1:0]     gpio_in_i,
    output logic [NUM_OUT-1:0]    gpio_out_o,
    output logic                  irq_o
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_e;
    typedef enum logic { R_IDLE, R_DATA } r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;

    logic [NUM_IN-1:0]  sync1_q, sync1_d;
    logic [NUM_IN-1:0]  sync2_q, sync2_d;
    logic [NUM_IN-1:0]  prev_q, prev_d;
    logic [NUM_IN-1:0]  irq_en_q, irq_en_d;
    logic [NUM_IN-1:0]  edge_sel_q, edge_sel_d;
    logic [NUM_IN-1:0]  status_q, status_d;
    logic [NUM_OUT-1:0] data_out_q, data_out_d;
    logic               irq_q, irq_d;
    logic               wready_q, wready_d;
    logic               bvalid_q, bvalid_d;
    logic [1:0]         bresp_q, bresp_d;
    logic               arready_q, arready_d;
    logic               rvalid_q, rvalid_d;
    logic [1:0]         rresp_q, rresp_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [NUM_IN-1:0]  edge_det;
    logic [NUM_IN-1:0]  status_clr;
    logic [31:0]        wr_mask;
    logic [2:0]         wr_idx;
    logic [2:0]         rd_idx;
    logic [31:0]        rd_val;
    logic               rd_err;

    // Address bits outside [4:2] and data bits above the register widths are
    // intentionally ignored; folding them here keeps them visibly consumed.
    logic unused_bits;
    assign unused_bits = ^{s_axilite_awaddr, s_axilite_araddr, s_axilite_wdata, wr_mask};

    assign wr_idx = s_axilite_awaddr[4:2];
    assign rd_idx = s_axilite_araddr[4:2];

    always_comb begin
        // Byte strobes expanded to a per-bit write mask.
        wr_mask = '0;
        for (int k = 0; k < 4; k++) begin
            wr_mask[8*k +: 8] = {8{s_axilite_wstrb[k]}};
        end

        // Edge detection on the synchronised value versus its previous sample.
        edge_det = (edge_sel_q & prev_q & ~sync2_q) | (~edge_sel_q & ~prev_q & sync2_q);

        // Read mux, evaluated against current (pre-update) register values.
        rd_val = '0;
        rd_err = 1'b0;
        case (rd_idx)
            3'd0:    rd_val[NUM_IN-1:0]  = sync2_q;
            3'd1:    rd_val[NUM_OUT-1:0] = data_out_q;
            3'd2:    rd_val[NUM_IN-1:0]  = irq_en_q;
            3'd3:    rd_val[NUM_IN-1:0]  = edge_sel_q;
            3'd4:    rd_val[NUM_IN-1:0]  = status_q;
            default: rd_err = 1'b1;
        endcase
    end

    always_comb begin
        sync1_d    = gpio_in_i;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        irq_en_d   = irq_en_q;
        edge_sel_d = edge_sel_q;
        data_out_d = data_out_q;
        status_clr = '0;
        w_state_d  = w_state_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        r_state_d  = r_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;

        // Write channel. wready_q doubles as awready: the ready pulse is raised
        // one cycle after both valids are seen, and the update happens in the
        // cycle the pulse is high.
        case (w_state_q)
            W_IDLE: begin
                if (wready_q) begin
                    wready_d = 1'b0;
                    if (s_axilite_awvalid && s_axilite_wvalid) begin
                        bvalid_d  = 1'b1;
                        bresp_d   = RESP_OKAY;
                        w_state_d = W_RESP;
                        case (wr_idx)
                            3'd0: ;
                            3'd1: data_out_d = (data_out_q & ~wr_mask[NUM_OUT-1:0]) |
                                               (s_axilite_wdata[NUM_OUT-1:0] & wr_mask[NUM_OUT-1:0]);
                            3'd2: irq_en_d   = (irq_en_q & ~wr_mask[NUM_IN-1:0]) |
                                               (s_axilite_wdata[NUM_IN-1:0] & wr_mask[NUM_IN-1:0]);
                            3'd3: edge_sel_d = (edge_sel_q & ~wr_mask[NUM_IN-1:0]) |
                                               (s_axilite_wdata[NUM_IN-1:0] & wr_mask[NUM_IN-1:0]);
                            3'd4: status_clr = s_axilite_wdata[NUM_IN-1:0] & wr_mask[NUM_IN-1:0];
                            default: bresp_d = RESP_SLVERR;
                        endcase
                    end
                end else if (s_axilite_awvalid && s_axilite_wvalid) begin
                    wready_d = 1'b1;
                end
            end
            W_RESP: begin
                if (s_axilite_bready) begin
                    bvalid_d  = 1'b0;
                    bresp_d   = RESP_OKAY;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        // Read channel: arready pulse, then data captured in the accept cycle.
        case (r_state_q)
            R_IDLE: begin
                if (arready_q) begin
                    arready_d = 1'b0;
                    if (s_axilite_arvalid) begin
                        rvalid_d  = 1'b1;
                        rdata_d   = rd_val;
                        rresp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
                        r_state_d = R_DATA;
                    end
                end else if (s_axilite_arvalid) begin
                    arready_d = 1'b1;
                end
            end
            R_DATA: begin
                if (s_axilite_rready) begin
                    rvalid_d  = 1'b0;
                    rdata_d   = '0;
                    rresp_d   = RESP_OKAY;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        // Edge set is applied after the clear so a coincident set wins.
        status_d = (status_q & ~status_clr) | edge_det;
        irq_d    = |(status_q & irq_en_q);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            irq_en_q   <= '0;
            edge_sel_q <= '0;
            status_q   <= '0;
            data_out_q <= '0;
            irq_q      <= 1'b0;
            w_state_q  <= W_IDLE;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            r_state_q  <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            irq_en_q   <= irq_en_d;
            edge_sel_q <= edge_sel_d;
            status_q   <= status_d;
            data_out_q <= data_out_d;
            irq_q      <= irq_d;
            w_state_q  <= w_state_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            r_state_q  <= r_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    assign s_axilite_awready = wready_q;
    assign s_axilite_wready  = wready_q;
    assign s_axilite_bvalid  = bvalid_q;
    assign s_axilite_bresp   = bresp_q;
    assign s_axilite_arready = arready_q;
    assign s_axilite_rvalid  = rvalid_q;
    assign s_axilite_rresp   = rresp_q;
    assign s_axilite_rdata   = rdata_q;
    assign gpio_out_o        = data_out_q;
    assign irq_o             = irq_q;

endmodule

// File: tb/tb_axilite_gpio_irq.sv
// -----------------------------------------------------------------------------
// tb_axilite_gpio_irq
//
// Directed and randomized stimulus for axilite_gpio_irq, checked against a
// register-level model of the GPIO block (register values, pin levels and the
// edge rules), with a final one-line report.
// -----------------------------------------------------------------------------
module tb_axilite_gpio_irq;

    localparam int NI = 16;
    localparam int NO = 16;
    localparam int AW = 32;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam int TMO = 20;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [AW-1:0] awaddr;
    logic          awvalid, awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid, wready;
    logic [1:0]    bresp;
    logic          bvalid, bready;
    logic [AW-1:0] araddr;
    logic          arvalid, arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid, rready;
    logic [NI-1:0] gpio_in;
    logic [NO-1:0] gpio_out;
    logic          irq;

    axilite_gpio_irq #(.NUM_IN(NI), .NUM_OUT(NO), .ADDR_WIDTH(AW)) dut (
        .clock_i(clk), .reset_i(rst),
        .s_axilite_awaddr(awaddr), .s_axilite_awvalid(awvalid), .s_axilite_awready(awready),
        .s_axilite_wdata(wdata), .s_axilite_wstrb(wstrb), .s_axilite_wvalid(wvalid),
        .s_axilite_wready(wready),
        .s_axilite_bresp(bresp), .s_axilite_bvalid(bvalid), .s_axilite_bready(bready),
        .s_axilite_araddr(araddr), .s_axilite_arvalid(arvalid), .s_axilite_arready(arready),
        .s_axilite_rdata(rdata), .s_axilite_rresp(rresp), .s_axilite_rvalid(rvalid),
        .s_axilite_rready(rready),
        .gpio_in_i(gpio_in), .gpio_out_o(gpio_out), .irq_o(irq)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    logic [NI-1:0] m_pins, m_en, m_sel, m_status;
    logic [NO-1:0] m_out;
    logic [NO-1:0] out_before, out_after;

    function automatic void model_reset();
        m_pins = '0; m_en = '0; m_sel = '0; m_status = '0; m_out = '0;
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                               input logic [3:0] s);
        for (int i = 0; i < 32; i++) begin
            if (s[i/8]) begin
                if (a[4:2] == 3'd1 && i < NO) m_out[i] = d[i];
                if (a[4:2] == 3'd2 && i < NI) m_en[i]  = d[i];
                if (a[4:2] == 3'd3 && i < NI) m_sel[i] = d[i];
                if (a[4:2] == 3'd4 && i < NI && d[i]) m_status[i] = 1'b0;
            end
        end
        return (a[4:2] > 3'd4) ? SLVERR : OKAY;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        case (a[4:2])
            3'd0:    return 32'(m_pins);
            3'd1:    return 32'(m_out);
            3'd2:    return 32'(m_en);
            3'd3:    return 32'(m_sel);
            3'd4:    return 32'(m_status);
            default: return 32'h0;
        endcase
    endfunction

    // A pin moving in the direction its EDGE_SEL bit selects sets its flag.
    function automatic void model_pins(input logic [NI-1:0] v);
        for (int i = 0; i < NI; i++) begin
            if (m_pins[i] != v[i]) begin
                if ((m_sel[i] == 1'b0 && v[i] == 1'b1) || (m_sel[i] == 1'b1 && v[i] == 1'b0))
                    m_status[i] = 1'b1;
            end
        end
        m_pins = v;
    endfunction

    function automatic logic model_irq();
        return (m_status & m_en) != '0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int n;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        resp = 2'bxx;
        n = 0;
        while (!awready && n < TMO) begin tick(1); n++; end
        if (n >= TMO) begin
            checks++; failures++;
            $display("FAIL write_accept_timeout addr=%h got awready=%b want 1", a, awready);
            awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
            return;
        end
        out_before = gpio_out;
        tick(1);
        awvalid = 1'b0; wvalid = 1'b0;
        out_after = gpio_out;
        n = 0;
        while (!bvalid && n < TMO) begin tick(1); n++; end
        if (n >= TMO) begin
            checks++; failures++;
            $display("FAIL write_resp_timeout addr=%h got bvalid=%b want 1", a, bvalid);
            bready = 1'b0;
            return;
        end
        resp = bresp;
        tick(1);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        d = 'x; resp = 2'bxx;
        n = 0;
        while (!arready && n < TMO) begin tick(1); n++; end
        if (n >= TMO) begin
            checks++; failures++;
            $display("FAIL read_accept_timeout addr=%h got arready=%b want 1", a, arready);
            arvalid = 1'b0; rready = 1'b0;
            return;
        end
        tick(1);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < TMO) begin tick(1); n++; end
        if (n >= TMO) begin
            checks++; failures++;
            $display("FAIL read_data_timeout addr=%h got rvalid=%b want 1", a, rvalid);
            rready = 1'b0;
            return;
        end
        d = rdata; resp = rresp;
        tick(1);
        rready = 1'b0;
    endtask

    task automatic set_pins(input logic [NI-1:0] v);
        gpio_in = v;
        model_pins(v);
        tick(5);
    endtask

    task automatic check_read(input string name, input logic [31:0] a);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(a, d, r);
        checks++;
        if (d !== model_read(a) || r !== ((a[4:2] > 3'd4) ? SLVERR : OKAY)) begin
            failures++;
            $display("FAIL %s addr=%h got data=%h resp=%b want data=%h resp=%b", name, a, d, r,
                     model_read(a), (a[4:2] > 3'd4) ? SLVERR : OKAY);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] r, er;
        er = model_write(a, d, s);
        axi_write(a, d, s, r);
        checks++;
        if (r !== er) begin
            failures++;
            $display("FAIL write_resp addr=%h got %b want %b", a, r, er);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0; gpio_in = '0;
        model_reset();
        tick(3);
        checks++;
        if ({gpio_out, irq, awready, wready, arready, bvalid, rvalid, bresp, rresp} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got out=%h irq=%b awr=%b wr=%b arr=%b bv=%b rv=%b want all 0",
                     gpio_out, irq, awready, wready, arready, bvalid, rvalid);
        end
        rst = 1'b0;
        tick(2);
        for (int a = 0; a <= 'h10; a += 4) check_read("reset_read", 32'(a));
        check_read("reset_read_bad14", 32'h14);
        check_read("reset_read_bad1c", 32'h1C);
    endtask

    task automatic test_data_out();
        do_write(32'h04, 32'hDEADBEEF, 4'b0011);
        checks++;
        if (out_before !== 16'h0000 || out_after !== 16'hBEEF) begin
            failures++;
            $display("FAIL data_out_timing got before=%h after=%h want 0000 beef", out_before, out_after);
        end
        check_read("data_out_read", 32'h04);
        do_write(32'h04, 32'h12345678, 4'b1100);
        do_write(32'h04, 32'h0000AA55, 4'b0010);
        checks++;
        if (gpio_out !== 16'hAAEF) begin
            failures++;
            $display("FAIL data_out_strobe got %h want aaef", gpio_out);
        end
        do_write(32'h00, 32'hFFFFFFFF, 4'hF);
        check_read("data_in_ro", 32'h00);
        do_write(32'h18, 32'hFFFFFFFF, 4'hF);
        check_read("bad_write_no_effect", 32'h04);
    endtask

    task automatic test_rise_irq();
        logic [31:0] d;
        logic [1:0]  r;
        do_write(32'h08, 32'h1, 4'hF);
        do_write(32'h0C, 32'h0, 4'hF);
        gpio_in[0] = 1'b1;
        axi_read(32'h00, d, r);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL data_in_latency_early got %h want 0", d);
        end
        model_pins(gpio_in);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_latency_early got %b want 0", irq);
        end
        tick(1);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_rise got %b want 1", irq);
        end
        check_read("data_in_bit0", 32'h00);
        check_read("status_rise", 32'h10);
        do_write(32'h10, 32'h1, 4'h1);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_clear got %b want 0", irq);
        end
        check_read("status_cleared", 32'h10);
        set_pins('0);
        check_read("status_no_fall", 32'h10);
    endtask

    task automatic test_fall();
        do_write(32'h0C, 32'h2, 4'hF);
        do_write(32'h08, 32'h0, 4'hF);
        set_pins(16'h0002);
        check_read("fall_sel_rise_ignored", 32'h10);
        set_pins(16'h0000);
        check_read("fall_sel_fall_sets", 32'h10);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL fall_irq_masked got %b want 0", irq);
        end
        do_write(32'h10, 32'hFFFF, 4'hF);
        do_write(32'h0C, 32'h0, 4'hF);
    endtask

    task automatic test_collision();
        logic [1:0]  r;
        logic [31:0] d;
        logic [1:0]  rr;
        do_write(32'h08, 32'h1, 4'hF);
        gpio_in[0] = 1'b1;
        tick(1);
        // W1C accepted on the same edge the rising edge sets the flag.
        axi_write(32'h10, 32'h1, 4'hF, r);
        void'(model_write(32'h10, 32'h1, 4'hF));
        model_pins(gpio_in);
        check_read("set_beats_clear", 32'h10);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL collision_irq got %b want 1", irq);
        end
        // Read of STATUS concurrent with its clear sees the old value.
        fork
            axi_write(32'h10, 32'h1, 4'hF, r);
            axi_read(32'h10, d, rr);
        join
        checks++;
        if (d !== 32'h1 || rr !== OKAY) begin
            failures++;
            $display("FAIL read_during_clear got %h/%b want 00000001/00", d, rr);
        end
        void'(model_write(32'h10, 32'h1, 4'hF));
        check_read("after_concurrent_clear", 32'h10);
        set_pins('0);
    endtask

    task automatic test_back_to_back();
        int n;
        awaddr = 32'h04; wdata = 32'h1234; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0;
        bready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checks++;
            if (awready !== 1'b0 || wready !== 1'b0) begin
                failures++;
                $display("FAIL aw_only_no_accept cyc=%0d got awready=%b wready=%b want 0 0",
                         i, awready, wready);
            end
        end
        wvalid = 1'b1;
        tick(1);
        checks++;
        if (awready !== 1'b1 || wready !== 1'b1) begin
            failures++;
            $display("FAIL joint_ready got awready=%b wready=%b want 1 1", awready, wready);
        end
        tick(1);
        awvalid = 1'b0; wvalid = 1'b0;
        void'(model_write(32'h04, 32'h1234, 4'hF));
        checks++;
        if (awready !== 1'b0 || bvalid !== 1'b1 || gpio_out !== m_out) begin
            failures++;
            $display("FAIL single_pulse got awready=%b bvalid=%b out=%h want 0 1 %h",
                     awready, bvalid, gpio_out, m_out);
        end
        awvalid = 1'b1; wvalid = 1'b1; wdata = 32'h5678;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checks++;
            if (bvalid !== 1'b1 || awready !== 1'b0) begin
                failures++;
                $display("FAIL resp_hold cyc=%0d got bvalid=%b awready=%b want 1 0", i, bvalid, awready);
            end
        end
        bready = 1'b1;
        tick(1);
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0) begin
            failures++;
            $display("FAIL resp_done got bvalid=%b want 0", bvalid);
        end
        n = 0;
        while (!awready && n < TMO) begin tick(1); n++; end
        checks++;
        if (n >= TMO) begin
            failures++;
            $display("FAIL second_write_timeout got awready=%b want 1", awready);
        end
        tick(1);
        awvalid = 1'b0; wvalid = 1'b0;
        void'(model_write(32'h04, 32'h5678, 4'hF));
        checks++;
        if (gpio_out !== m_out || bvalid !== 1'b1) begin
            failures++;
            $display("FAIL second_write got out=%h bvalid=%b want %h 1", gpio_out, bvalid, m_out);
        end
        bready = 1'b1;
        tick(1);
        bready = 1'b0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 80; it++) begin
            int op;
            logic [31:0] a;
            op = $urandom_range(0, 2);
            a = {$urandom_range(0, 7), 5'b0} | {27'b0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            case (op)
                0: do_write(a, $urandom, 4'($urandom_range(0, 15)));
                1: check_read("rand_read", a);
                default: set_pins(NI'($urandom));
            endcase
            checks++;
            if (gpio_out !== m_out || irq !== model_irq()) begin
                failures++;
                $display("FAIL rand_outputs it=%0d got out=%h irq=%b want %h %b",
                         it, gpio_out, irq, m_out, model_irq());
            end
        end
        for (int a = 0; a <= 'h10; a += 4) check_read("rand_final", 32'(a));
        set_pins('0);
    endtask

    task automatic test_reset_mid();
        int n;
        awaddr = 32'h04; wdata = 32'hFFFF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h04; arvalid = 1'b1;
        n = 0;
        while (!awready && n < TMO) begin tick(1); n++; end
        rst = 1'b1;
        #1;
        checks++;
        if (awready !== 1'b0 || wready !== 1'b0 || arready !== 1'b0 || gpio_out !== '0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got awr=%b wr=%b arr=%b out=%h irq=%b want 0 0 0 0 0",
                     awready, wready, arready, gpio_out, irq);
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        model_reset();
        tick(2);
        rst = 1'b0;
        tick(3);
        checks++;
        if (bvalid !== 1'b0 || rvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_replay got bvalid=%b rvalid=%b want 0 0", bvalid, rvalid);
        end
        for (int a = 0; a <= 'h10; a += 4) check_read("after_reset_mid", 32'(a));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_data_out();
        test_rise_irq();
        test_fall();
        test_collision();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
